// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between NUM_REQ producers.
// Throttles on full/almostfull, routes wr_ack back to the owning producer and counts overflows.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [NUM_REQ-1:0]            done_ack,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  idx_t                  last_gnt_q, last_gnt_d;
  idx_t                  owner_q, owner_d;
  idx_t                  ack_owner_q, ack_owner_d;  // owner delayed to line up with wr_ack
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  busy_q, busy_d;
  logic [1:0]            ack_arm_q, ack_arm_d;

  logic                  issue_ok;
  logic                  gnt_vld;
  logic [NUM_REQ-1:0]    hi_req;
  logic [NUM_REQ-1:0]    cand;
  idx_t                  gnt_idx;
  logic [FIFO_WIDTH-1:0] gnt_data;

  // Rotating priority: lowest requester above last_gnt wins, otherwise wrap to the lowest overall.
  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    issue_ok = arb_en & ~fifo_full & ~(wr_en_q & fifo_almostfull);
    hi_req   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i > int'(last_gnt_q)) hi_req[i] = req[i];
    end
    cand    = (|hi_req) ? hi_req : req;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) gnt_idx = idx_t'(i);
    end
    gnt_vld  = rst_n & issue_ok & (|req);
    gnt      = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == idx_t'(i)) gnt_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    ack_owner_d = owner_q;
    wr_en_d     = 1'b0;
    data_d      = data_q;
    ack_arm_d   = {ack_arm_q[0], 1'b1};
    // A write on the bus keeps busy set even if an older write completes this cycle.
    busy_d      = wr_en_q | (busy_q & ~(fifo_wr_ack | fifo_overflow));
    drop_cnt_d  = drop_cnt_q;
    if (fifo_overflow && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (gnt_vld) begin
      wr_en_d    = 1'b1;
      data_d     = gnt_data;
      owner_d    = gnt_idx;
      last_gnt_d = gnt_idx;
      busy_d     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= idx_t'(NUM_REQ - 1);
      owner_q     <= '0;
      ack_owner_q <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
      ack_arm_q   <= 2'b00;
    end else begin
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      ack_owner_q <= ack_owner_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= busy_d;
      ack_arm_q   <= ack_arm_d;
    end
  end

  // Acks are ignored for two cycles after reset release; they belong to pre-reset writes.
  always_comb begin
    done_ack = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      done_ack[k] = fifo_wr_ack & ack_arm_q[1] & (ack_owner_q == idx_t'(k));
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign drop_cnt     = drop_cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter with a behavioural FIFO (DEPTH=8)
// and a round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int W        = 16;
  localparam int N        = 4;
  localparam int CW       = 8;
  localparam int DEPTH    = 8;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           arb_en;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic [N-1:0]   done_ack;
  logic [CW-1:0]  drop_cnt;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .req_data(req_data),
    .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .done_ack(done_ack), .drop_cnt(drop_cnt), .busy(busy)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t wr_q[$];
  exp_t ack_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Producer / environment knobs
  logic [W-1:0] pdata [N];
  logic [N-1:0] mask;
  int keep_pct, raise_pct, rd_pct, arb_pct, data_mode;
  logic force_ovf;
  int late_ack_n;
  int occ, n_acc;

  // Reference model state
  int           m_last, m_owner, m_drop;
  logic         m_wr, g1, g2;
  logic [W-1:0] m_data;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pdata[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] next_data(input int i);
    if (data_mode != 0) return W'((i + 1) * 32'h1111);
    return W'($urandom);
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_owner = 0; m_drop = 0;
    m_wr = 1'b0; g1 = 1'b0; g2 = 1'b0; m_data = '0;
    wr_q.delete();
    ack_q.delete();
  endtask

  task automatic reset_checks();
    check("rst_gnt",      64'(gnt),          64'(0));
    check("rst_wr_en",    64'(fifo_wr_en),   64'(0));
    check("rst_data_in",  64'(fifo_data_in), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt),     64'(0));
    check("rst_busy",     64'(busy),         64'(0));
    check("rst_done_ack", 64'(done_ack),     64'(0));
  endtask

  // One clock cycle: model/check mid-cycle, then FIFO + producers react after the edge.
  task automatic tick();
    logic [N-1:0] s_gnt;
    logic         s_wr, issue, acc, rej, rd;
    int           pick;
    #2;
    s_gnt = gnt;
    s_wr  = fifo_wr_en;
    issue = arb_en && !fifo_full && !(m_wr && fifo_almostfull);
    pick  = issue ? rr_pick(req, m_last) : -1;
    check("gnt", 64'(gnt), (pick >= 0) ? (64'(1) << pick) : 64'(0));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("busy", 64'(busy), 64'(g1 | g2));
    if (!m_wr) check("data_hold", 64'(fifo_data_in), 64'(m_data));
    if (m_wr && !fifo_full) ack_q.push_back('{cyc + 1, 32'(1) << m_owner});
    if (fifo_overflow && m_drop < DROP_MAX) m_drop++;
    g2   = g1;
    g1   = (pick >= 0);
    m_wr = (pick >= 0);
    if (pick >= 0) begin
      m_owner = pick;
      m_last  = pick;
      m_data  = pdata[pick];
      wr_q.push_back('{cyc + 1, 32'(pdata[pick])});
    end

    @(posedge clk);
    cyc++;
    #1;
    acc = s_wr && (occ < DEPTH);
    rej = s_wr && (occ == DEPTH);
    rd  = ($urandom_range(99) < rd_pct) && (occ > 0);
    occ = occ + int'(acc) - int'(rd);
    n_acc += int'(acc);
    fifo_wr_ack   = acc || (late_ack_n > 0);
    if (late_ack_n > 0) late_ack_n--;
    fifo_overflow = rej || force_ovf;
    fifo_full       = (occ == DEPTH);
    fifo_almostfull = (occ == DEPTH - 1);
    for (int i = 0; i < N; i++) begin
      if (req[i] && s_gnt[i]) begin
        req[i]   = mask[i] && ($urandom_range(99) < keep_pct);
        pdata[i] = next_data(i);
      end else if (!req[i] && mask[i] && ($urandom_range(99) < raise_pct)) begin
        req[i]   = 1'b1;
        pdata[i] = next_data(i);
      end
    end
    if (arb_pct < 100) arb_en = ($urandom_range(99) < arb_pct);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    int k = 0;
    req = '0;
    mask = '0;
    rd_pct = 100;
    run(3);
    while (occ != 0 && k < 20) begin
      tick();
      k++;
    end
    check("drain_empty", 64'(occ), 64'(0));
  endtask

  // Scoreboard monitor: compares FIFO-side outputs against queued expectations.
  always @(negedge clk) begin
    logic        exp_wr;
    logic [31:0] exp_ack;
    exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
    check("wr_en", 64'(fifo_wr_en), 64'(exp_wr));
    if (exp_wr) begin
      if (fifo_wr_en) check("wr_data", 64'(fifo_data_in), 64'(wr_q[0].val));
      void'(wr_q.pop_front());
    end
    exp_ack = '0;
    if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
      exp_ack = ack_q[0].val;
      void'(ack_q.pop_front());
    end
    check("done_ack", 64'(done_ack), 64'(exp_ack));
  end

  initial begin
    for (int i = 0; i < N; i++) pdata[i] = '0;
    mask = '0; keep_pct = 0; raise_pct = 0; rd_pct = 100; arb_pct = 100; data_mode = 1;
    force_ovf = 1'b0; late_ack_n = 0; occ = 0; n_acc = 0;
    fifo_full = 1'b0; fifo_almostfull = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
    model_reset();

    // Reset: grants suppressed even with every producer requesting
    rst_n = 1'b0; arb_en = 1'b1; req = '1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;

    // Single requester with a fixed word
    req = 4'b0001; pdata[0] = 16'hA5A5; mask = 4'b0001;
    run(6);

    // All four continuously with distinct data
    mask = '1; keep_pct = 100; req = '1;
    for (int i = 0; i < N; i++) pdata[i] = next_data(i);
    run(16);

    // Fill from requester 2 with no reads: exactly DEPTH writes, never an overflow
    drain();
    data_mode = 0; mask = 4'b0100; req = 4'b0100; pdata[2] = next_data(2);
    keep_pct = 100; rd_pct = 0; n_acc = 0;
    run(30);
    check("fill_writes", 64'(n_acc), 64'(DEPTH));
    check("fill_occ", 64'(occ), 64'(DEPTH));

    // Forced overflow for 300 cycles saturates the drop counter
    req = '0; mask = '0;
    force_ovf = 1'b1; fifo_overflow = 1'b1;
    run(300);
    force_ovf = 1'b0; fifo_overflow = 1'b0;
    run(2);
    check("drop_sat", 64'(drop_cnt), 64'(DROP_MAX));

    // Arbitration disabled, then re-enabled
    drain();
    arb_en = 1'b0; mask = '1; keep_pct = 100; req = '1;
    for (int i = 0; i < N; i++) pdata[i] = next_data(i);
    run(5);
    arb_en = 1'b1;
    run(8);

    // Random traffic with back-pressure and arb_en toggling
    keep_pct = 50; raise_pct = 40; rd_pct = 45; arb_pct = 90;
    run(800);
    arb_pct = 100; arb_en = 1'b1;

    // Reset while an ack is due; a late ack follows release
    drain();
    mask = '1; keep_pct = 100; raise_pct = 0; req = '1;
    for (int i = 0; i < N; i++) pdata[i] = next_data(i);
    run(2);
    rst_n = 1'b0;
    late_ack_n = 1;
    #1;
    reset_checks();
    model_reset();
    rst_n = 1'b1;
    run(10);

    drain();
    check("queues_empty", 64'(wr_q.size() + ack_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
